// File: rtl/regfile_wb_scheduler_if.sv
// Bundle between decode, the ALU/LSU writeback sources and the register-file write port.
// Bypass signals exist only when REGFILE_WB_BYPASS_EN is defined.
interface regfile_wb_scheduler_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            issue_valid;
  logic [RA_W-1:0] issue_rd;
  logic [RA_W-1:0] issue_rs1;
  logic [RA_W-1:0] issue_rs2;
  logic            issue_stall;
  logic            alu_valid;
  logic [RA_W-1:0] alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  logic [RA_W-1:0] lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            w_en;
  logic [RA_W-1:0] w_a;
  logic [XLEN-1:0] w_d;
`ifdef REGFILE_WB_BYPASS_EN
  logic            byp1_en;
  logic [XLEN-1:0] byp1_d;
  logic            byp2_en;
  logic [XLEN-1:0] byp2_d;
`endif

  modport master (
`ifdef REGFILE_WB_BYPASS_EN
    input  byp1_en, byp1_d, byp2_en, byp2_d,
`endif
    output issue_valid, issue_rd, issue_rs1, issue_rs2,
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  issue_stall, alu_ready, lsu_ready,
    input  w_en, w_a, w_d
  );

  modport slave (
`ifdef REGFILE_WB_BYPASS_EN
    output byp1_en, byp1_d, byp2_en, byp2_d,
`endif
    input  issue_valid, issue_rd, issue_rs1, issue_rs2,
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output issue_stall, alu_ready, lsu_ready,
    output w_en, w_a, w_d
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates ALU/LSU writebacks onto the single register-file write port and keeps the busy
// scoreboard for decode hazards. Define REGFILE_WB_BYPASS_EN to forward the write port to decode.
module regfile_wb_scheduler #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input logic                   clock,
  input logic                   reset_n,
  regfile_wb_scheduler_if.slave bus
);
  // state    | meaning
  // LAST_ALU | ALU won the last contested cycle; LSU wins the next one
  // LAST_LSU | LSU won the last contested cycle; ALU wins the next one
  typedef enum logic {LAST_ALU = 1'b0, LAST_LSU = 1'b1} rr_state_t;

  localparam int NREG = 1 << RA_W;

  rr_state_t       rr_q, rr_d;
  logic [NREG-1:0] busy, busy_d;
  logic            grant_alu, grant_lsu;
  logic [RA_W-1:0] grant_rd;
  logic [XLEN-1:0] grant_d;
  logic            issue_fire;
  logic            src1_hz, src2_hz, dst_hz;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rr_q <= LAST_ALU;
    else          rr_q <= rr_d;
  end

  always_comb begin
    rr_d      = rr_q;
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (bus.alu_valid && bus.lsu_valid) begin
      if (rr_q == LAST_ALU) begin
        grant_lsu = 1'b1;
        rr_d      = LAST_LSU;
      end else begin
        grant_alu = 1'b1;
        rr_d      = LAST_ALU;
      end
    end else begin
      grant_alu = bus.alu_valid;
      grant_lsu = bus.lsu_valid;
    end
  end

  assign bus.alu_ready = grant_alu;
  assign bus.lsu_ready = grant_lsu;
  assign grant_rd      = grant_lsu ? bus.lsu_rd   : bus.alu_rd;
  assign grant_d       = grant_lsu ? bus.lsu_data : bus.alu_data;

  // A grant to x0 still consumes the slot but never raises the write enable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.w_en <= 1'b0;
      bus.w_a  <= '0;
      bus.w_d  <= '0;
    end else if (grant_alu || grant_lsu) begin
      bus.w_en <= (grant_rd != '0);
      bus.w_a  <= grant_rd;
      bus.w_d  <= grant_d;
    end else begin
      bus.w_en <= 1'b0;
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  logic byp1_hit, byp2_hit;
  assign byp1_hit    = bus.w_en && (bus.w_a != '0) && (bus.w_a == bus.issue_rs1);
  assign byp2_hit    = bus.w_en && (bus.w_a != '0) && (bus.w_a == bus.issue_rs2);
  assign bus.byp1_en = byp1_hit;
  assign bus.byp1_d  = bus.w_d;
  assign bus.byp2_en = byp2_hit;
  assign bus.byp2_d  = bus.w_d;
  assign src1_hz     = busy[bus.issue_rs1] && !byp1_hit;
  assign src2_hz     = busy[bus.issue_rs2] && !byp2_hit;
`else
  assign src1_hz     = busy[bus.issue_rs1];
  assign src2_hz     = busy[bus.issue_rs2];
`endif
  assign dst_hz          = busy[bus.issue_rd];
  assign bus.issue_stall = bus.issue_valid && (src1_hz || src2_hz || dst_hz);
  assign issue_fire      = bus.issue_valid && !bus.issue_stall;

  // Set is applied after clear so a same-edge set/clear of one register leaves it busy.
  always_comb begin
    busy_d = busy;
    if (bus.w_en) busy_d[bus.w_a] = 1'b0;
    if (issue_fire && (bus.issue_rd != '0)) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= busy_d;
  end

  a_no_same_rd: assert property (@(posedge clock) disable iff (!reset_n)
    !(bus.alu_valid && bus.lsu_valid && (bus.alu_rd == bus.lsu_rd) && (bus.alu_rd != '0)));
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios with literal expectations, then random
// traffic compared every cycle against a scoreboard/arbiter model kept in the bench.
module tb_regfile_wb_scheduler;
  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;
  bit   chk_en  = 1'b1;

  regfile_wb_scheduler_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();
  regfile_wb_scheduler #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // Model: set of busy registers, the registered write port, and who won the last contest.
  logic [31:0] m_busy = '0;
  bit          m_wen  = 1'b0;
  logic [4:0]  m_wa   = '0;
  logic [31:0] m_wd   = '0;
  int          m_last = 0;     // 0: ALU won last contest, 1: LSU
  bit          m_iss_acc = 1'b0, m_alu_acc = 1'b0, m_lsu_acc = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  function automatic bit src_hazard(logic [4:0] r);
    if (r == 5'd0) return 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
    if (m_wen && m_wa == r) return 1'b0;
`endif
    return m_busy[r];
  endfunction

  function automatic bit exp_stall();
    return bus.issue_valid && (src_hazard(bus.issue_rs1) || src_hazard(bus.issue_rs2) ||
                               (bus.issue_rd != 5'd0 && m_busy[bus.issue_rd]));
  endfunction

  // 0: no grant, 1: ALU, 2: LSU
  function automatic int exp_winner();
    if (bus.alu_valid && bus.lsu_valid) return (m_last == 0) ? 2 : 1;
    if (bus.lsu_valid) return 2;
    if (bus.alu_valid) return 1;
    return 0;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = '0; m_wen = 1'b0; m_wa = '0; m_wd = '0; m_last = 0;
      m_iss_acc = 1'b0; m_alu_acc = 1'b0; m_lsu_acc = 1'b0;
    end else begin
      int w;
      w = exp_winner();
      m_iss_acc = bus.issue_valid && !exp_stall();
      m_alu_acc = (w == 1);
      m_lsu_acc = (w == 2);
      if (m_wen) m_busy[m_wa] = 1'b0;
      if (m_iss_acc && bus.issue_rd != 5'd0) m_busy[bus.issue_rd] = 1'b1;
      if (bus.alu_valid && bus.lsu_valid) m_last = (w == 2) ? 1 : 0;
      if (w != 0) begin
        m_wa  = (w == 2) ? bus.lsu_rd : bus.alu_rd;
        m_wd  = (w == 2) ? bus.lsu_data : bus.alu_data;
        m_wen = (m_wa != 5'd0);
      end else begin
        m_wen = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      int w;
      w = exp_winner();
      check("cyc_stall", 32'(bus.issue_stall), 32'(exp_stall()));
      check("cyc_alu_ready", 32'(bus.alu_ready), 32'(w == 1));
      check("cyc_lsu_ready", 32'(bus.lsu_ready), 32'(w == 2));
      check("cyc_w_en", 32'(bus.w_en), 32'(m_wen));
      if (m_wen) begin
        check("cyc_w_a", 32'(bus.w_a), 32'(m_wa));
        check("cyc_w_d", bus.w_d, m_wd);
      end
`ifdef REGFILE_WB_BYPASS_EN
      check("cyc_byp1_en", 32'(bus.byp1_en), 32'(m_wen && m_wa != 0 && m_wa == bus.issue_rs1));
      check("cyc_byp2_en", 32'(bus.byp2_en), 32'(m_wen && m_wa != 0 && m_wa == bus.issue_rs2));
      if (bus.byp1_en) check("cyc_byp1_d", bus.byp1_d, m_wd);
      if (bus.byp2_en) check("cyc_byp2_d", bus.byp2_d, m_wd);
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [4:0] pick_rd(logic [4:0] avoid);
    for (int k = 0; k < 8; k++) begin
      logic [4:0] r;
      r = 5'($urandom_range(0, 7));
      if ((r == 5'd0 || r != avoid) && (m_busy[r] || $urandom_range(0, 3) == 0)) return r;
    end
    return 5'd0;
  endfunction

  initial begin
    bus.issue_valid = 1'b1; bus.issue_rs1 = 5'd5; bus.issue_rs2 = 5'd6; bus.issue_rd = 5'd7;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    #2;
    check("rst_stall", 32'(bus.issue_stall), 32'd0);
    check("rst_w_en", 32'(bus.w_en), 32'd0);
    check("rst_w_a", 32'(bus.w_a), 32'd0);
    check("rst_w_d", bus.w_d, 32'd0);
    check("rst_ready", 32'({bus.alu_ready, bus.lsu_ready}), 32'd0);
    #10 reset_n = 1'b1;

    // RAW on x7 resolved by an ALU writeback
    tick();
    bus.issue_rs1 = 5'd7; bus.issue_rs2 = 5'd0; bus.issue_rd = 5'd0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'hDEADBEEF;
    #1;
    check("raw_stall", 32'(bus.issue_stall), 32'd1);
    check("raw_alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    bus.alu_valid = 1'b0;
    #1;
    check("raw_w_en", 32'(bus.w_en), 32'd1);
    check("raw_w_a", 32'(bus.w_a), 32'd7);
    check("raw_w_d", bus.w_d, 32'hDEADBEEF);
`ifdef REGFILE_WB_BYPASS_EN
    check("raw_byp_stall", 32'(bus.issue_stall), 32'd0);
    check("raw_byp1_en", 32'(bus.byp1_en), 32'd1);
    check("raw_byp1_d", bus.byp1_d, 32'hDEADBEEF);
`else
    check("raw_hold_stall", 32'(bus.issue_stall), 32'd1);
`endif
    tick();
    #1;
    check("raw_release", 32'(bus.issue_stall), 32'd0);
    bus.issue_valid = 1'b0;

    // contested writebacks: LSU, ALU, LSU, ALU
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hA0;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_alu_ready", 32'(bus.alu_ready), 32'(i % 2 == 1));
      check("rr_lsu_ready", 32'(bus.lsu_ready), 32'(i % 2 == 0));
      tick();
      #1;
      check("rr_w_a", 32'(bus.w_a), (i % 2 == 1) ? 32'd3 : 32'd4);
      check("rr_w_d", bus.w_d, (i % 2 == 1) ? 32'hA0 : 32'hB0);
    end
    bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;

    // writeback to x0
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1234;
    #1;
    check("x0_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    bus.alu_valid = 1'b0;
    #1;
    check("x0_w_en", 32'(bus.w_en), 32'd0);

    // WAW on x9 and same-edge set/clear
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; bus.issue_rs1 = 5'd0; bus.issue_rs2 = 5'd0;
    #1;
    check("waw_first", 32'(bus.issue_stall), 32'd0);
    tick();
    #1;
    check("waw_stall", 32'(bus.issue_stall), 32'd1);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
    #1;
    check("waw_alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    bus.alu_valid = 1'b0;
    #1;
    check("waw_w_a", 32'(bus.w_a), 32'd9);
    check("waw_wr_cycle", 32'(bus.issue_stall), 32'd1);
    tick();
    #1;
    check("waw_reissue", 32'(bus.issue_stall), 32'd0);
    tick();
    bus.issue_rd = 5'd0; bus.issue_rs1 = 5'd9;
    #1;
    check("waw_busy_again", 32'(bus.issue_stall), 32'd1);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h77;
    tick();
    bus.alu_valid = 1'b0; bus.issue_valid = 1'b0;
    tick();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h55;
    tick();
    bus.alu_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; bus.issue_rs1 = 5'd0;
    #1;
    check("same_w_en", 32'(bus.w_en), 32'd1);
    check("same_issue", 32'(bus.issue_stall), 32'd0);
    tick();
    bus.issue_rd = 5'd0; bus.issue_rs1 = 5'd9;
    #1;
    check("same_set_wins", 32'(bus.issue_stall), 32'd1);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h66;
    tick();
    bus.alu_valid = 1'b0; bus.issue_valid = 1'b0;
    tick();
    bus.issue_valid = 1'b1;
    #1;
    check("waw_cleared", 32'(bus.issue_stall), 32'd0);

    // reset mid-stream
    bus.issue_rd = 5'd2; bus.issue_rs1 = 5'd0;
    tick();
    bus.issue_rd = 5'd3;
    tick();
    bus.issue_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h22;
    tick();
    bus.alu_valid = 1'b0;
    #1;
    check("mid_w_en_before", 32'(bus.w_en), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_w_en_dropped", 32'(bus.w_en), 32'd0);
    tick();
    #3 reset_n = 1'b1;
    tick();
    bus.issue_valid = 1'b1; bus.issue_rs1 = 5'd2; bus.issue_rs2 = 5'd3; bus.issue_rd = 5'd0;
    #1;
    check("mid_no_stall", 32'(bus.issue_stall), 32'd0);
    tick();
    bus.issue_valid = 1'b0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (i == 1500) begin
        reset_n = 1'b0;
        bus.issue_valid = 1'b0; bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
        tick();
        #2 reset_n = 1'b1;
        continue;
      end
      if (!bus.issue_valid || m_iss_acc) begin
        bus.issue_valid = ($urandom_range(0, 99) < 60);
        bus.issue_rd  = 5'($urandom_range(0, 7));
        bus.issue_rs1 = 5'($urandom_range(0, 7));
        bus.issue_rs2 = 5'($urandom_range(0, 7));
      end
      if (!bus.alu_valid || m_alu_acc) begin
        bus.alu_valid = ($urandom_range(0, 1) == 1);
        if (bus.alu_valid) begin
          bus.alu_rd   = pick_rd((bus.lsu_valid && !m_lsu_acc) ? bus.lsu_rd : 5'd0);
          bus.alu_data = $urandom;
        end
      end
      if (!bus.lsu_valid || m_lsu_acc) begin
        bus.lsu_valid = ($urandom_range(0, 1) == 1);
        if (bus.lsu_valid) begin
          bus.lsu_rd   = pick_rd(bus.alu_valid ? bus.alu_rd : 5'd0);
          bus.lsu_data = $urandom;
        end
      end
    end
    bus.issue_valid = 1'b0; bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
